// File: rtl/ldpc_pkg.sv
// Shared constants and FSM state encoding for the QC-LDPC variable-node scheduler.
package ldpc_pkg;

    localparam int NCOL         = 24;
    localparam int AW           = 5;
    localparam int VNU_LAT_DEF  = 1;
    localparam int MAX_ITER_DEF = 8;
    localparam int IW           = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_CHECK,
        ST_DONE
    } state_t;

endpackage

// File: rtl/vnu_valid_delay.sv
// {valid, addr} shift register that tracks RAM read plus VNU latency; flush drops every in-flight entry.
module vnu_valid_delay
    import ldpc_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    output logic          mid_valid,
    output logic          out_valid,
    output logic [AW-1:0] out_addr
);

    logic [DEPTH-1:0] v;
    logic [AW-1:0]    a [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) a[i] <= '0;
        end else if (flush) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) a[i] <= '0;
        end else begin
            v    <= {v[DEPTH-2:0], in_valid};
            a[0] <= in_addr;
            for (int i = 1; i < DEPTH; i++) a[i] <= a[i-1];
        end
    end

    // Stage 0 is the cycle RAM data reaches the VNU; the last stage is the VNU result.
    assign mid_valid = v[0];
    assign out_valid = v[DEPTH-1];
    assign out_addr  = a[DEPTH-1];

endmodule

// File: rtl/vnu_iteration_scheduler.sv
// Sequences one VNU over all columns per decoding iteration, collects hard decisions,
// and repeats until the syndrome check passes or the iteration limit is hit.
module vnu_iteration_scheduler
    import ldpc_pkg::*;
#(
    parameter int VNU_LAT  = VNU_LAT_DEF,
    parameter int MAX_ITER = MAX_ITER_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    // Strobes are single-cycle qualifiers with no back-pressure: rd_en/vnu_valid/wr_en mark the
    // cycle their data is valid, chk_req asks once, chk_done answers any later cycle in CHECK.
    input  logic            start,
    input  logic            abort,
    output logic            rd_en,
    output logic [AW-1:0]   rd_addr,
    output logic            vnu_valid,
    output logic            wr_en,
    output logic [AW-1:0]   wr_addr,
    input  logic            vnu_c,
    output logic            chk_req,
    input  logic            chk_done,
    input  logic            chk_pass,
    output logic            busy,
    output logic            done,
    output logic            success,
    output logic [IW-1:0]   iter_cnt,
    output logic [NCOL-1:0] hard_dec,
    output state_t          dbg_state
);

    localparam int            DW         = (VNU_LAT < 2) ? 1 : $clog2(VNU_LAT + 1);
    localparam logic [AW-1:0] LAST_COL   = AW'(NCOL - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(VNU_LAT);
    localparam logic [IW-1:0] LAST_ITER  = IW'(MAX_ITER - 1);

    state_t          state;
    logic [DW-1:0]   drain_cnt;

    assign dbg_state = state;

    vnu_valid_delay #(
        .DEPTH(1 + VNU_LAT)
    ) u_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (abort),
        .in_valid (rd_en),
        .in_addr  (rd_addr),
        .mid_valid(vnu_valid),
        .out_valid(wr_en),
        .out_addr (wr_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            drain_cnt <= '0;
            chk_req   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            success   <= 1'b0;
            iter_cnt  <= '0;
        end else if (abort) begin
            state   <= ST_IDLE;
            rd_en   <= 1'b0;
            chk_req <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done    <= 1'b0;
            chk_req <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_LOAD;
                        rd_en    <= 1'b1;
                        rd_addr  <= '0;
                        busy     <= 1'b1;
                        iter_cnt <= '0;
                        success  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (rd_addr == LAST_COL) begin
                        rd_en     <= 1'b0;
                        drain_cnt <= '0;
                        state     <= ST_DRAIN;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == LAST_DRAIN) begin
                        state   <= ST_CHECK;
                        chk_req <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    // A response in the request cycle cannot belong to this request.
                    if (chk_done && !chk_req) begin
                        iter_cnt <= iter_cnt + 1'b1;
                        if (chk_pass || iter_cnt == LAST_ITER) begin
                            state   <= ST_DONE;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            success <= chk_pass;
                        end else begin
                            state   <= ST_LOAD;
                            rd_en   <= 1'b1;
                            rd_addr <= '0;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hard_dec <= '0;
        end else if (!abort) begin
            if (state == ST_IDLE && start) begin
                hard_dec <= '0;
            end else if (wr_en) begin
                for (int k = 0; k < NCOL; k++) begin
                    if (wr_addr == AW'(k)) hard_dec[k] <= vnu_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_vnu_iteration_scheduler.sv
// Directed scoreboard bench: each run pushes its expected {success, iter_cnt, hard_dec}; a monitor pops on done.
module tb_vnu_iteration_scheduler;
    import ldpc_pkg::*;

    localparam int W = 1 + IW + NCOL;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start, abort, vnu_c, chk_done, chk_pass;
    logic            rd_en, vnu_valid, wr_en, chk_req, busy, done, success;
    logic [AW-1:0]   rd_addr, wr_addr;
    logic [IW-1:0]   iter_cnt;
    logic [NCOL-1:0] hard_dec;
    state_t          dbg_state;

    logic [W-1:0]    exp_q[$];
    logic [NCOL-1:0] words [8];
    logic            pass_at [8];
    int              iter_idx;
    logic            abort_on_chk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_start;
    int first_rd, last_rd, rd_cnt, first_wr, last_wr, wr_cnt, chk_cyc, done_cyc;

    vnu_iteration_scheduler #(
        .VNU_LAT (1),
        .MAX_ITER(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .vnu_valid(vnu_valid),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .vnu_c    (vnu_c),
        .chk_req  (chk_req),
        .chk_done (chk_done),
        .chk_pass (chk_pass),
        .busy     (busy),
        .done     (done),
        .success  (success),
        .iter_cnt (iter_cnt),
        .hard_dec (hard_dec),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_rec();
        first_rd = -1; last_rd = -1; rd_cnt = 0;
        first_wr = -1; last_wr = -1; wr_cnt = 0;
        chk_cyc = -1;  done_cyc = -1;
    endtask

    // ---------------- drivers ----------------
    task automatic do_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        t_start = cyc;
        check("busy_after_start", busy, 1);
        check("iter_cnt_cleared", iter_cnt, 0);
        check("success_cleared", success, 0);
    endtask

    task automatic wait_q_empty(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL done_timeout: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic setup(input logic [NCOL-1:0] w0, input logic [NCOL-1:0] w1,
                         input logic [NCOL-1:0] w2, input int pass_iter);
        for (int i = 0; i < 8; i++) begin
            words[i]   = 24'h3C3C3C ^ NCOL'(i * 24'h010101);
            pass_at[i] = (i == pass_iter);
        end
        words[0] = w0; words[1] = w1; words[2] = w2;
        iter_idx = 0;
        clear_rec();
    endtask

    // VNU model: hard decision for the column being written back this cycle.
    always @(negedge clk) vnu_c = wr_en ? words[iter_idx][wr_addr] : 1'b0;

    // Syndrome checker: answers two cycles after each request.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_req && rst_n) begin
                @(posedge clk);
                @(posedge clk);
                #1;
                chk_done = 1'b1;
                chk_pass = pass_at[iter_idx];
                if (abort_on_chk) abort = 1'b1;
                @(posedge clk);
                #1;
                chk_done = 1'b0;
                chk_pass = 1'b0;
                if (abort_on_chk) abort = 1'b0;
                if (iter_idx < 7) iter_idx++;
            end
        end
    end

    // ---------------- monitors / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_en) begin
                check("rd_addr_seq", rd_addr, rd_cnt % NCOL);
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                rd_cnt++;
            end
            if (wr_en) begin
                check("wr_addr_seq", wr_addr, wr_cnt % NCOL);
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                wr_cnt++;
            end
            if (chk_req && chk_cyc < 0) chk_cyc = cyc;
        end
    end

    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (done && rst_n) begin
                done_cyc = cyc;
                check("busy_low_at_done", busy, 0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 with success=%0b iter_cnt=%0d, required no done", success, iter_cnt);
                end else begin
                    e = exp_q.pop_front();
                    check("done_result", {success, iter_cnt, hard_dec}, e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; vnu_c = 1'b0;
        chk_done = 1'b0; chk_pass = 1'b0; abort_on_chk = 1'b0;
        setup(24'h0, 24'h0, 24'h0, 9);
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_vnu_valid", vnu_valid, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_chk_req", chk_req, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_success", success, 0);
        check("rst_iter_cnt", iter_cnt, 0);
        check("rst_hard_dec", hard_dec, 0);
        check("rst_state", dbg_state, ST_IDLE);
        rst_n = 1'b1;

        // Pass on first iteration, with cycle-exact timing
        setup(24'h555555, 24'h0, 24'h0, 0);
        exp_q.push_back({1'b1, 4'd1, 24'h555555});
        do_start();
        wait_q_empty(200);
        check("t1_rd_first", first_rd - t_start, 0);
        check("t1_rd_last", last_rd - t_start, 23);
        check("t1_rd_cnt", rd_cnt, 24);
        check("t1_wr_first", first_wr - t_start, 2);
        check("t1_wr_last", last_wr - t_start, 25);
        check("t1_wr_cnt", wr_cnt, 24);
        check("t1_chk_req", chk_cyc - t_start, 26);
        check("t1_done", done_cyc - t_start, 29);
        check("t1_state_idle", dbg_state, ST_IDLE);

        // Never pass: stops after MAX_ITER, holds results
        setup(24'h111111, 24'h222222, 24'h333333, 9);
        words[7] = 24'h0F0F0F;
        exp_q.push_back({1'b0, 4'd8, 24'h0F0F0F});
        do_start();
        wait_q_empty(800);
        repeat (40) @(posedge clk);
        #1;
        check("t2_rd_cnt_8_bursts", rd_cnt, 192);
        check("t2_iter_held", iter_cnt, 8);
        check("t2_hard_dec_held", hard_dec, 24'h0F0F0F);

        // Pass on third iteration
        setup(24'h123456, 24'hABCDEF, 24'hC3C3C3, 2);
        exp_q.push_back({1'b1, 4'd3, 24'hC3C3C3});
        do_start();
        wait_q_empty(300);
        check("t3_rd_cnt", rd_cnt, 72);

        // Abort during LOAD at column 10
        setup(24'hFFFFFF, 24'h0, 24'h0, 0);
        do_start();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(rd_en && rd_addr == 5'd10) && n < 50);
        check("t4_reach_col10", rd_addr, 10);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("t4_rd_en_low", rd_en, 0);
        check("t4_wr_en_low", wr_en, 0);
        check("t4_vnu_valid_low", vnu_valid, 0);
        check("t4_busy_low", busy, 0);
        check("t4_state_idle", dbg_state, ST_IDLE);
        check("t4_iter_kept", iter_cnt, 0);
        repeat (40) @(negedge clk);
        check("t4_low_cols_kept", hard_dec[7:0], 8'hFF);
        check("t4_high_cols_unwritten", hard_dec[23:9], 0);
        setup(24'h555555, 24'h0, 24'h0, 0);
        exp_q.push_back({1'b1, 4'd1, 24'h555555});
        do_start();
        wait_q_empty(200);
        check("t4_restart_first_rd", first_rd - t_start, 0);

        // start while busy and chk_done during LOAD are both ignored
        setup(24'h00FFFF, 24'hABC123, 24'h0, 1);
        exp_q.push_back({1'b1, 4'd2, 24'hABC123});
        do_start();
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk_done = 1'b1;
        chk_pass = 1'b1;
        @(posedge clk);
        #1 chk_done = 1'b0;
        chk_pass = 1'b0;
        wait_q_empty(300);
        check("t5_rd_cnt", rd_cnt, 48);

        // chk_done together with abort: no done, iteration count untouched
        setup(24'h777777, 24'h0, 24'h0, 0);
        abort_on_chk = 1'b1;
        do_start();
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check("t6_busy_low", busy, 0);
        check("t6_state_idle", dbg_state, ST_IDLE);
        check("t6_iter_not_incr", iter_cnt, 0);
        check("t6_success_low", success, 0);
        abort_on_chk = 1'b0;

        // Asynchronous reset in the middle of DRAIN
        setup(24'hFFFFFF, 24'h0, 24'h0, 0);
        do_start();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (dbg_state != ST_DRAIN && n < 50);
        check("t7_reach_drain", dbg_state, ST_DRAIN);
        #2 rst_n = 1'b0;
        #1;
        check("t7_rst_wr_en", wr_en, 0);
        check("t7_rst_vnu_valid", vnu_valid, 0);
        check("t7_rst_busy", busy, 0);
        check("t7_rst_hard_dec", hard_dec, 0);
        check("t7_rst_wr_addr", wr_addr, 0);
        check("t7_rst_rd_addr", rd_addr, 0);
        check("t7_rst_state", dbg_state, ST_IDLE);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t7_idle_after_release", dbg_state, ST_IDLE);
        check("t7_no_chk_req", chk_cyc, -1);
        check("t7_no_rd_en", rd_en, 0);

        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
